// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: shared width helpers and operand extension for the pipelined adder tree
package adder_tree_pkg;
    localparam int MAX_W = 64;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    function automatic int out_width(input int n, input int w, input int acc);
        return w + clog2(n) + acc;
    endfunction
    function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] v, input int w, input bit sgn);
        logic [MAX_W-1:0] r;
        r = v;
        for (int i = 0; i < MAX_W; i++) if (i >= w) r[i] = sgn & v[w-1];
        return r;
    endfunction
endpackage

// File: rtl/adder_tree_level.sv
// adder_tree_level: one registered pairwise reduction level with its tag pipeline
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 4,
    parameter bit SIGNED = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N*W-1:0]         in_data,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic                   in_mode,
    output logic [(N/2)*(W+1)-1:0] out_data,
    output logic                   out_valid,
    output logic                   out_first,
    output logic                   out_last,
    output logic                   out_mode
);
    logic [(N/2)*(W+1)-1:0] sums;
    function automatic logic [W:0] ext(input logic [W-1:0] v);
        return (W+1)'(extend(MAX_W'(v), W, SIGNED));
    endfunction
    for (genvar i = 0; i < N/2; i++) begin : g_add
        assign sums[i*(W+1) +: W+1] = ext(in_data[2*i*W +: W]) + ext(in_data[(2*i+1)*W +: W]);
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_mode  <= 1'b0;
        end else begin
            out_data  <= sums;
            out_valid <= in_valid;
            out_first <= in_first;
            out_last  <= in_last;
            out_mode  <= in_mode;
        end
endmodule

// File: rtl/adder_tree_pipelined.sv
// adder_tree_pipelined: pipelined binary adder tree with tagged beats and a burst accumulator
module adder_tree_pipelined
    import adder_tree_pkg::*;
#(
    parameter int N_INPUTS  = 16,
    parameter int IN_WIDTH  = 4,
    parameter int SIGNED    = 0,
    parameter int ACC_BITS  = 8,
    parameter int CNT_WIDTH = 8,
    localparam int LEVELS    = clog2(N_INPUTS),
    localparam int OUT_WIDTH = out_width(N_INPUTS, IN_WIDTH, ACC_BITS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_INPUTS*IN_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic                         acc_mode,
    output logic [OUT_WIDTH-1:0]         sum_out,
    output logic                         out_valid,
    output logic [CNT_WIDTH-1:0]         out_count,
    output logic                         out_overflow
);
    localparam int TW = IN_WIDTH + LEVELS;
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int NI = N_INPUTS >> k;
        localparam int WI = IN_WIDTH + k;
        logic [NI*WI-1:0]         di;
        logic [(NI/2)*(WI+1)-1:0] d;
        logic                     vi, fi, li, mi, v, f, l, m;
        if (k == 0) begin : g_src
            assign {di, vi, fi, li, mi} = {in_data, in_valid, in_first, in_last, acc_mode};
        end else begin : g_src
            assign {di, vi, fi, li, mi} = {g_lvl[k-1].d, g_lvl[k-1].v, g_lvl[k-1].f, g_lvl[k-1].l, g_lvl[k-1].m};
        end
        adder_tree_level #(.N(NI), .W(WI), .SIGNED(SIGNED != 0)) u_level (
            .clk(clk), .reset(reset),
            .in_data(di), .in_valid(vi), .in_first(fi), .in_last(li), .in_mode(mi),
            .out_data(d), .out_valid(v), .out_first(f), .out_last(l), .out_mode(m)
        );
    end
    logic [TW-1:0]        tree;
    logic                 t_valid, t_first, t_last, t_mode;
    logic [OUT_WIDTH-1:0] tree_ext, base, acc, acc_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic                 ovf, ovf_n, carry, wrap;
    assign tree     = g_lvl[LEVELS-1].d;
    assign t_valid  = g_lvl[LEVELS-1].v;
    assign t_first  = g_lvl[LEVELS-1].f;
    assign t_last   = g_lvl[LEVELS-1].l;
    assign t_mode   = g_lvl[LEVELS-1].m;
    assign tree_ext = OUT_WIDTH'(extend(MAX_W'(tree), TW, SIGNED != 0));
    // wrap is two's-complement overflow for signed data, carry-out otherwise
    always_comb begin
        base = t_first ? '0 : acc;
        {carry, acc_n} = {1'b0, base} + {1'b0, tree_ext};
        wrap = (SIGNED != 0) ? (base[OUT_WIDTH-1] == tree_ext[OUT_WIDTH-1]) && (acc_n[OUT_WIDTH-1] != base[OUT_WIDTH-1]) : carry;
        cnt_n = t_first ? CNT_WIDTH'(1) : (&cnt ? cnt : cnt + CNT_WIDTH'(1));
        ovf_n = (ovf && !t_first) || wrap;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            acc          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            sum_out      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            out_valid <= t_valid && (!t_mode || t_last);
            if (t_valid && !t_mode) begin
                sum_out      <= tree_ext;
                out_count    <= CNT_WIDTH'(1);
                out_overflow <= 1'b0;
            end
            if (t_valid && t_mode) begin
                acc <= acc_n;
                cnt <= cnt_n;
                ovf <= ovf_n;
                if (t_last) begin
                    sum_out      <= acc_n;
                    out_count    <= cnt_n;
                    out_overflow <= ovf_n;
                end
            end
        end
endmodule
